// File: rtl/m3_mult_arbiter_pkg.sv
// Shared operand/product types for the multiplier arbiter slice.
package m3_mult_pkg;

    localparam int OPW = 24;
    localparam int ZW  = 48;

    typedef logic [OPW-1:0] op_t;
    typedef logic [ZW-1:0]  prod_t;

    typedef struct packed {
        op_t x;
        op_t y;
    } opnd_t;

endpackage

// File: rtl/m3_mult_arbiter_if.sv
// Requester and result handshake bundle between clients and the arbiter.
interface m3_mult_arbiter_if
    import m3_mult_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int TAGW = $clog2(NREQ);

    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    op_t             req_x [NREQ];
    op_t             req_y [NREQ];
    logic            res_valid;
    logic            res_ready;
    logic [TAGW-1:0] res_tag;
    prod_t           res_z;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_tag, res_z
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_tag, res_z
    );

endinterface

// File: rtl/M3booth_multiplier.sv
// Combinational 24x24 unsigned radix-4 Booth multiplier.
module M3booth_multiplier
    import m3_mult_pkg::*;
(
    input  op_t   x,
    input  op_t   y,
    output prod_t z
);

    always_comb begin
        logic [OPW+2:0] yb;
        logic [2:0]     trip;
        prod_t          xe;
        prod_t          pp;
        prod_t          acc;
        // two zero MSBs make the top digit non-negative for unsigned y
        yb   = {2'b00, y, 1'b0};
        xe   = prod_t'(x);
        acc  = '0;
        trip = '0;
        pp   = '0;
        for (int unsigned i = 0; i < (OPW + 2) / 2; i++) begin
            trip = 3'(yb >> (2 * i));
            case (trip)
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        z = acc;
    end

endmodule

// File: rtl/m3_mult_arbiter_rr.sv
// Round-robin priority rotate: first valid request at or after ptr wins.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int TAGW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [TAGW-1:0] gnt_idx,
    output logic            any
);

    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[idx[TAGW-1:0]]) begin
                any                 = 1'b1;
                gnt_idx             = idx[TAGW-1:0];
                gnt[idx[TAGW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m3_mult_arbiter.sv
// Shares one Booth multiplier among NREQ requesters: RR arbitration, two-stage
// pipeline around the multiplier, tagged results with valid/ready backpressure.
module m3_mult_arbiter
    import m3_mult_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    m3_mult_arbiter_if.slave bus,
    output logic             idle
);

    localparam int              TAGW = $clog2(NREQ);
    localparam logic [TAGW-1:0] LAST = TAGW'(NREQ - 1);

    logic [TAGW-1:0] ptr_q,    ptr_d;
    logic            s1_v_q,   s1_v_d;
    opnd_t           s1_op_q,  s1_op_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;
    logic            s2_v_q,   s2_v_d;
    prod_t           s2_z_q,   s2_z_d;
    logic [TAGW-1:0] s2_tag_q, s2_tag_d;

    logic [NREQ-1:0] gnt;
    logic [TAGW-1:0] gnt_idx;
    logic            any;
    logic            adv1, adv2, accept;
    prod_t           mult_z;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    M3booth_multiplier u_mult (
        .x (s1_op_q.x),
        .y (s1_op_q.y),
        .z (mult_z)
    );

    always_comb begin
        adv2     = !s2_v_q || bus.res_ready;
        adv1     = !s1_v_q || adv2;
        // req_ready is held low while reset is asserted
        accept   = any && adv1 && rst;
        bus.req_ready = accept ? gnt : '0;

        ptr_d    = ptr_q;
        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_tag_d = s1_tag_q;
        s2_v_d   = s2_v_q;
        s2_z_d   = s2_z_q;
        s2_tag_d = s2_tag_q;

        if (adv1) begin
            s1_v_d = accept;
            if (accept) begin
                s1_op_d.x = bus.req_x[gnt_idx];
                s1_op_d.y = bus.req_y[gnt_idx];
                s1_tag_d  = gnt_idx;
                ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + TAGW'(1);
            end
        end

        if (adv2) begin
            s2_v_d   = s1_v_q;
            s2_z_d   = mult_z;
            s2_tag_d = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            s1_v_q   <= 1'b0;
            s1_op_q  <= '0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_z_q   <= '0;
            s2_tag_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_v_q   <= s1_v_d;
            s1_op_q  <= s1_op_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            s2_z_q   <= s2_z_d;
            s2_tag_q <= s2_tag_d;
        end
    end

    assign bus.res_valid = s2_v_q;
    assign bus.res_tag   = s2_tag_q;
    assign bus.res_z     = s2_z_q;
    assign idle          = !s1_v_q && !s2_v_q;

endmodule

// File: tb/tb_m3_mult_arbiter.sv
// Self-checking bench for m3_mult_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based transaction model.
module tb_m3_mult_arbiter;
    import m3_mult_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic idle;

    always #5 clk = ~clk;

    m3_mult_arbiter_if #(.NREQ(N)) bus ();

    m3_mult_arbiter #(.NREQ(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .idle (idle)
    );

    typedef struct {
        int    tag;
        prod_t z;
        int    stage;
    } item_t;

    item_t       q[$];
    logic [N-1:0] mv;
    op_t         mx [N];
    op_t         my [N];
    logic        rr;
    int          mptr;
    logic [N-1:0] arm_mask;
    int          arm_pct;
    int          gnt_log[$];
    prod_t       z_log[$];
    int          n_assert;
    int          n_fail;

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t pick_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return op_t'($urandom);
    endfunction

    task automatic cycle();
        bit    s1f, s2f, adv1, adv2, found, xfer;
        int    g, c, dut_g;
        logic [N-1:0] exp_rdy;
        prod_t seen_z;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!mv[i] && arm_mask[i] && (int'($urandom_range(0, 99)) < arm_pct)) begin
                mv[i] = 1'b1;
                mx[i] = pick_op();
                my[i] = pick_op();
            end
        end
        bus.req_valid = mv;
        for (int i = 0; i < N; i++) begin
            bus.req_x[i] = mx[i];
            bus.req_y[i] = my[i];
        end
        bus.res_ready = rr;
        #1;
        s1f = 1'b0;
        s2f = 1'b0;
        foreach (q[k]) begin
            if (q[k].stage == 2) s2f = 1'b1;
            else s1f = 1'b1;
        end
        adv2  = !s2f || rr;
        adv1  = !s1f || adv2;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            c = (mptr + k) % N;
            if (!found && mv[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        exp_rdy = '0;
        if (found && adv1) exp_rdy[g] = 1'b1;
        check(64'(bus.req_ready), 64'(exp_rdy), "req_ready");
        check(64'(bus.res_valid), 64'(s2f), "res_valid");
        if (s2f) begin
            check(64'(bus.res_tag), 64'(q[0].tag), "res_tag");
            check(64'(bus.res_z), 64'(q[0].z), "res_z");
        end
        check(64'(idle), 64'(q.size() == 0), "idle");
        dut_g = -1;
        for (int k = 0; k < N; k++) if (bus.req_ready[k] === 1'b1) dut_g = k;
        xfer   = (bus.res_valid === 1'b1) && rr;
        seen_z = bus.res_z;

        @(posedge clk);
        if (dut_g >= 0) gnt_log.push_back(dut_g);
        if (xfer) z_log.push_back(seen_z);
        if (s2f && rr) q.pop_front();
        if (adv2) foreach (q[k]) q[k].stage = 2;
        if (found && adv1) begin
            item_t it;
            it.tag   = g;
            it.z     = prod_t'(mx[g]) * prod_t'(my[g]);
            it.stage = 1;
            q.push_back(it);
            mptr  = (g + 1) % N;
            mv[g] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n       = 0;
        arm_pct = 0;
        rr      = 1'b1;
        while ((q.size() != 0 || mv != '0) && n < 40) begin
            cycle();
            n++;
        end
        #1;
        check(64'(idle && (mv == '0)), 64'(1), "drain_done");
    endtask

    task automatic check_reset_outputs(input string tag);
        check(64'(bus.res_valid), 64'(0), {tag, "_res_valid"});
        check(64'(bus.res_tag), 64'(0), {tag, "_res_tag"});
        check(64'(bus.res_z), 64'(0), {tag, "_res_z"});
        check(64'(idle), 64'(1), {tag, "_idle"});
        check(64'(bus.req_ready), 64'(0), {tag, "_req_ready"});
    endtask

    task automatic reset_dut(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        mv   = '0;
        mptr = 0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, xbase;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        rr       = 1'b0;
        mv       = '0;
        mptr     = 0;
        arm_mask = '0;
        arm_pct  = 0;
        bus.req_valid = '1;
        bus.res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            mx[i] = '0;
            my[i] = '0;
            bus.req_x[i] = '0;
            bus.req_y[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        rst = 1'b1;

        // round-robin with all requesters continuously valid
        base     = gnt_log.size();
        xbase    = z_log.size();
        arm_mask = 4'b1111;
        arm_pct  = 100;
        rr       = 1'b1;
        repeat (12) cycle();
        for (int i = 0; i < 12; i++)
            check(64'(gnt_log[base + i]), 64'(i % 4), "rr_order");
        check(64'(z_log.size() - xbase), 64'(10), "rr_throughput");
        drain();

        // single request, latency and idle return
        arm_mask = '0;
        mv[2] = 1'b1;
        mx[2] = 24'd3;
        my[2] = 24'd5;
        cycle();
        cycle();
        #1;
        check(64'(bus.res_valid), 64'(1), "single_valid");
        check(64'(bus.res_tag), 64'(2), "single_tag");
        check(64'(bus.res_z), 64'(15), "single_z");
        cycle();
        #1;
        check(64'(idle), 64'(1), "single_idle");

        // maximum and zero operands
        xbase = z_log.size();
        mv[0] = 1'b1; mx[0] = 24'hFFFFFF; my[0] = 24'hFFFFFF;
        mv[1] = 1'b1; mx[1] = 24'hFFFFFF; my[1] = 24'h000000;
        drain();
        check(64'(z_log[xbase]), 64'(48'hFFFFFE000001), "max_z");
        check(64'(z_log[xbase + 1]), 64'(0), "zero_z");

        // backpressure: three requests, only two fit
        base  = gnt_log.size();
        xbase = z_log.size();
        rr    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b1;
            mx[i] = pick_op();
            my[i] = pick_op();
        end
        repeat (6) cycle();
        #1;
        check(64'(gnt_log.size() - base), 64'(2), "bp_accepts");
        check(64'(bus.req_ready), 64'(0), "bp_ready_low");
        drain();
        check(64'(z_log.size() - xbase), 64'(3), "bp_drained");

        // sparse requesters 1 and 3 starting from ptr 2
        reset_dut("rst_sparse");
        mv[1] = 1'b1;
        mx[1] = 24'd7;
        my[1] = 24'd9;
        drain();
        base     = gnt_log.size();
        arm_mask = 4'b1010;
        arm_pct  = 100;
        repeat (8) cycle();
        for (int i = 0; i < 8; i++)
            check(64'(gnt_log[base + i]), 64'((i % 2 == 0) ? 3 : 1), "sparse_order");
        drain();

        // reset with both stages full
        arm_mask = 4'b1111;
        arm_pct  = 100;
        rr       = 1'b0;
        repeat (3) cycle();
        #1;
        check(64'(idle), 64'(0), "mid_busy");
        check(64'(bus.res_valid), 64'(1), "mid_valid");
        reset_dut("rst_mid");
        xbase    = z_log.size();
        arm_pct  = 0;
        rr       = 1'b1;
        repeat (5) cycle();
        check(64'(z_log.size() - xbase), 64'(0), "mid_no_stale");

        // random traffic with random backpressure
        base     = gnt_log.size();
        xbase    = z_log.size();
        arm_mask = 4'b1111;
        arm_pct  = 40;
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();
        check(64'(z_log.size() - xbase), 64'(gnt_log.size() - base), "rand_conserve");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/m3_mult_arbiter.md
# m3_mult_arbiter

Shares one 24×24 unsigned Booth multiplier datapath (`M3booth_multiplier`) between `NREQ` independent requesters. Round-robin arbitration, a two-stage pipeline around the combinational multiplier, and tagged results on a single result port with valid/ready backpressure. Sits between the LSTM datapath clients (gate/state scaling units) and the multiplier. Sustains one product per cycle when unstalled.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `TAGW`, default `$clog2(NREQ)`: tag width. Derived; not overridden.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in [NREQ]: operand pair i is valid.
- `req_ready` out [NREQ]: operand pair i is accepted this cycle. At most one bit is high.
- `req_x` in [NREQ][24]: multiplicand i, unsigned.
- `req_y` in [NREQ][24]: multiplier i, unsigned.
- `res_valid` out 1: the result on `res_z`/`res_tag` is valid.
- `res_ready` in 1: the consumer accepts the result.
- `res_tag` out TAGW: index of the requester that produced the result.
- `res_z` out 48: exact unsigned product `req_x*req_y`.
- `idle` out 1: no operation is in flight. Both stages are empty.

## Operation
- **Pipeline stages**
  - S1 holds registered x, y, tag and `s1_v`.
  - The multiplier is combinational on the S1 registers.
  - S2 holds registered z, tag and `s2_v`.
  - The result port drives directly from S2.
- **Advance conditions**
  - `adv2 = !s2_v | res_ready`.
  - `adv1 = !s1_v | adv2`.
- **Arbitration**
  - Round-robin pointer `ptr` (TAGW bits).
  - Search order: `ptr, ptr+1, …` mod NREQ. The first index with `req_valid` set is the winner `g`.
  - `req_ready[g] = adv1`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `s1_v`, `s2_v` and `res_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- **On accept** (`req_valid[g] & req_ready[g]`):
  - S1 is loaded with `req_x[g]`, `req_y[g]` and `g`.
  - `ptr <= (g+1) mod NREQ`.
- **No accept while `adv1`:** `s1_v <= 0`.
- **Pointer hold:** `ptr` holds when no request is accepted.
- **S2 update**
  - When `adv2`, S2 loads `{mult_z, s1_tag}` and `s2_v <= s1_v`.
  - Otherwise S2 holds.
- **Result transfer:** occurs on `res_valid & res_ready`.
- **Result integrity:** no result is ever dropped or duplicated. Results leave in acceptance order.
- **Requester contract:** a requester holds `req_x`, `req_y` and `req_valid` stable until accepted (AXI-style).
- **Idle:** `idle = !s1_v & !s2_v`.

## Timing
- **Reset state:** `s1_v=0`, `s2_v=0`, `ptr=0`, `res_valid=0`, `res_tag=0`, `res_z=0`, `idle=1`, all `req_ready=0`.
- **Reset mid-operation:** in-flight operations are discarded without output.
- **Latency:** accept on edge t gives `res_valid=1` after edge t+1, i.e. visible in cycle t+2 when unstalled.
- **Throughput:** one accept per cycle with `res_ready` held high.
- **Stall:**
  - `res_valid & !res_ready` freezes S2.
  - If S1 is also full, `req_ready` drops to 0 in the same cycle.
  - Pipeline depth 2: at most 2 operations are buffered.
- **Simultaneous S2 drain and S1 refill:** allowed in one cycle. This is full throughput.
- **Pointer wrap-around:** `ptr` wraps from NREQ−1 to 0.
- **Single requester:** a lone active requester is accepted every cycle regardless of `ptr`.
- **Fairness bound:** a continuously valid requester waits at most NREQ−1 accepts.
- **Zero operands:** x=0 or y=0 gives z=0, with no special path.

## Structure
- **Package `m3_mult_pkg`**
  - `localparam OPW=24`, `ZW=48`.
  - `typedef logic [OPW-1:0] op_t`.
  - `typedef logic [ZW-1:0] prod_t`.
  - `typedef struct packed {op_t x; op_t y;} opnd_t`.
- **Sub-module `rr_arbiter`** (parameter NREQ): `req[NREQ]`, `ptr` → one-hot `gnt` plus `gnt_idx` and `any`. Pure combinational priority rotate.
- **Register ownership:** the top level owns `ptr` and the pipeline registers.
- **Multiplier:** the existing `M3booth_multiplier` is instantiated unchanged (x, y → z).

## Test plan
- **Single request:** reset, then req 2 with x=3, y=5 for one accept → `res_valid` two cycles later, `res_tag=2`, `res_z=15`, `idle` back to 1 one cycle after transfer.
- **Round-robin:** all 4 requesters continuously valid, `res_ready=1` → accept order 0,1,2,3,0,…, tags match, one result per cycle.
- **Maximum operands:** x=y=0xFFFFFF → `res_z=0xFFFFFE000001`. Also x=0xFFFFFF, y=0 → 0.
- **Backpressure:** hold `res_ready=0` with 3 back-to-back requests → exactly 2 accepted, `req_ready` all 0 after that, `res_z`/`res_tag` stable. Release → remaining results drain in order with none lost.
- **Reset mid-flight:** assert `rst` low with S1 and S2 full → outputs return to reset values immediately. No stale result appears after release.
- **Sparse requesters:** only req 1 and req 3 valid, `ptr` starting at 2 → grant 3 then 1, alternating.
